// File: rtl/seq_mult_8x8_ctrl.sv
// seq_mult_8x8_ctrl
// Shift-add 8x8 unsigned multiplier controller. Each iteration it drives an
// external 8-bit ripple-carry adder, holds the operands for ADD_WAIT cycles so
// the ripple can settle, then captures {Co,S} and shifts the 17-bit result
// right into the accumulator. Eight iterations give the 16-bit product.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               request, sampled only in IDLE
//   mcand, mplier       operands, sampled on the start edge
//   busy, done          busy from start edge to the cycle after done; done is a 1-cycle pulse
//   product             16-bit result, held until the next done
//   add_a, add_b        adder operands (add_b is m or 0 depending on acc_lo[0])
//   add_cin             adder carry-in, tied to 0
//   add_s, add_co       adder sum and carry-out
//   add_err             (only with ADD_CHECK_EN) sticky flag: captured {Co,S}
//                       disagreed with an internal reference add
//
// Optional feature macro: ADD_CHECK_EN
//
// state | meaning
// IDLE  | waiting for start
// ADD   | operands on adder; counting ADD_WAIT cycles, capture on last
// DONE  | product valid, done pulse; return to IDLE next edge

module seq_mult_8x8_ctrl #(
    parameter int unsigned ADD_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_s,
    input  logic        add_co
`ifdef ADD_CHECK_EN
    ,
    output logic        add_err
`endif
);

    localparam int unsigned WAIT_W = (ADD_WAIT > 1) ? $clog2(ADD_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADD_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         acc_hi_q, acc_hi_d;
    logic [7:0]         acc_lo_q, acc_lo_d;
    logic [7:0]         m_q, m_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        product_q, product_d;
    logic               capture;
    logic [15:0]        shifted;

    // Right shift of {Co, S, acc_lo}: the carry lands in the product MSB.
    assign shifted = {add_co, add_s, acc_lo_q[7:1]};

    always_comb begin
        state_d    = state_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        m_d        = m_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        product_d  = product_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_hi_d   = 8'h00;
                    acc_lo_d   = mplier;
                    m_d        = mcand;
                    bit_cnt_d  = 4'd0;
                    wait_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = ADD;
                end
            end
            ADD: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    capture    = 1'b1;
                    acc_hi_d   = shifted[15:8];
                    acc_lo_d   = shifted[7:0];
                    wait_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        product_d = shifted;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_hi_q   <= 8'h00;
            acc_lo_q   <= 8'h00;
            m_q        <= 8'h00;
            bit_cnt_q  <= 4'd0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            m_q        <= m_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            product_q  <= product_d;
        end
    end

    // Operands come straight from registers, so they only move on capture
    // (and start) edges; all-zero registers give zero operands after reset.
    assign add_a   = acc_hi_q;
    assign add_b   = acc_lo_q[0] ? m_q : 8'h00;
    assign add_cin = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

`ifdef ADD_CHECK_EN
    logic       add_err_q, add_err_d;
    logic [8:0] ref_sum;

    assign ref_sum = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    always_comb begin
        add_err_d = add_err_q;
        if (capture && ({add_co, add_s} != ref_sum)) begin
            add_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_err_q <= 1'b0;
        end else begin
            add_err_q <= add_err_d;
        end
    end

    assign add_err = add_err_q;
`endif

endmodule

// File: doc/seq_mult_8x8_ctrl.md
Name: seq_mult_8x8_ctrl

Overview:
- Sequential shift-add 8x8 unsigned multiplier controller. Sits directly upstream of the 8-bit ripple-carry adder (Full_Adder_8bit) and consumes its sum and carry outputs.
- Drives the adder's A, B and Cin inputs each iteration, waits a programmable number of cycles for the ripple to settle, then captures S/Co and shifts.
- Produces a 16-bit product with a start/busy/done handshake.

Parameters:
- ADD_WAIT, 2, clock cycles the adder operands are held before S/Co are captured (>=1). Must cover the adder ripple delay, 8 stages x 1 ns plus margin.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mcand  in  8  multiplicand; sampled on the start edge.
- mplier  in  8  multiplier; sampled on the start edge.
- busy  out  1  high from the start edge until the cycle after done.
- done  out  1  one-cycle pulse when product is valid.
- product  out  16  result; held until the next done.
- add_a  out  8  to adder A.
- add_b  out  8  to adder B.
- add_cin  out  1  to adder Cin; constant 0.
- add_s  in  8  from adder S.
- add_co  in  1  from adder Co.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. Asserting reset forces state=IDLE and zeroes busy, done, product, add_a, add_b, the internal registers and the counters. The requirement applies mid-operation; the partial result is discarded.
- Internal registers: acc_hi[7:0], acc_lo[7:0], m[7:0], bit_cnt[3:0], wait_cnt sized for ADD_WAIT.
- IDLE:
  - With start=1 at edge t: acc_hi=0, acc_lo=mplier, m=mcand, bit_cnt=0, wait_cnt=0, busy=1, state moves to ADD.
  - With start=0: hold.
- ADD, operand drive:
  - add_a=acc_hi.
  - add_b = m if acc_lo[0]=1, else 0x00.
  - Operands change only on capture edges and stay stable for the full ADD_WAIT window.
- ADD, waiting: each edge with wait_cnt<ADD_WAIT-1 increments wait_cnt.
- ADD, capture edge (wait_cnt==ADD_WAIT-1):
  - {acc_hi,acc_lo} <= {add_co,add_s,acc_lo[7:1]}, a 17-bit right shift of {Co,S,acc_lo}.
  - wait_cnt=0, bit_cnt++.
- ADD, after the 8th capture (bit_cnt reaches 8): product is loaded with the shifted result on the same edge, done=1, state moves to DONE.
- Latency: done is high in the cycle following edge t+8*ADD_WAIT.
- DONE: next edge clears done and busy, and state returns to IDLE. start is ignored in DONE. Earliest restart is the edge after DONE.
- start while busy or in DONE: ignored, not queued; operands are unaffected.
- Arithmetic: unsigned. The carry from each add enters the product MSB through the shift, so there is no overflow. 0xFF*0xFF=0xFE01 must be exact.
- mcand/mplier changes after the start edge have no effect.
- product changes only on the final capture edge and on reset.

Optional Feature:
- Macro: ADD_CHECK_EN.
- Defined: adds output add_err (1 bit, reset 0). On every capture edge the block compares {add_co,add_s} against an internal 9-bit add_a+add_b+add_cin. On mismatch add_err sets and stays set (sticky) until reset. This catches an ADD_WAIT too short for the adder delay.
- Undefined: no add_err port and no comparator; behaviour is otherwise identical.

Test Plan:
- ADD_WAIT=2, start with mcand=0x0F, mplier=0x0F: product=0x00E1, done one cycle, exactly 16 cycles after the start edge; busy low the cycle after.
- mcand=0xFF, mplier=0xFF: product=0xFE01 (exercises add_co into the MSB); 0xFF*0x01=0x00FF; 0x00*0xA5=0x0000 with the full latency.
- start pulsed in every cycle while busy with different operands: a single result 0x0F*0x0F=0x00E1; no second done until a fresh start in IDLE.
- Assert reset at cycle 5 of an operation: busy, done, product and add_a/add_b go to 0 immediately (asynchronously). Then start 0x12*0x34: product=0x03A8.
- Rebuild with ADD_WAIT=1 and ADD_WAIT=4 and run 0xC8*0x03=0x0258: done at start+8 and start+32 respectively; add_a/add_b stable between captures.
- With ADD_CHECK_EN defined, run against a correct adder for 3 products and confirm add_err=0. Then force add_s bit 3 wrong on one capture: add_err=1 and it stays set until reset.
